// File: rtl/pipeline_debug_ctrl.sv
// Debug sequencer for the five-stage pipeline: run, single step, flush and
// register-bank dump to the TX path, with register port A arbitration.
module pipeline_debug_ctrl #(
   parameter int unsigned NB_DATA = 32,
   parameter int unsigned NB_REG  = 5,
   parameter int unsigned N_REGS  = 32,
   parameter int unsigned NB_CMD  = 8
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_cmd_valid,
   input  logic [NB_CMD-1:0]  i_cmd,
   output logic               o_cmd_ready,
   input  logic               i_halt,
   output logic               o_pipe_enable,
   output logic               o_pipe_flush,
   output logic               o_dbg_rd_sel,
   output logic [NB_REG-1:0]  o_dbg_reg_addr,
   input  logic [NB_DATA-1:0] i_dbg_reg_data,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic [2:0]         o_state
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StRun    = 3'd1,
      StStep   = 3'd2,
      StDumpRd = 3'd3,
      StDumpTx = 3'd4,
      StFlush  = 3'd5,
      StHalted = 3'd6
   } state_e;

   localparam logic [NB_CMD-1:0] CmdRun   = NB_CMD'(8'h43);
   localparam logic [NB_CMD-1:0] CmdStep  = NB_CMD'(8'h53);
   localparam logic [NB_CMD-1:0] CmdDump  = NB_CMD'(8'h52);
   localparam logic [NB_CMD-1:0] CmdFlush = NB_CMD'(8'h58);
   localparam logic [NB_REG-1:0] LastAddr = NB_REG'(N_REGS - 1);

   state_e              state_q, state_d;
   logic [NB_REG-1:0]   addr_q, addr_d;
   logic [NB_DATA-1:0]  tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   // Set while the pipeline sits halted; also selects where a dump returns to.
   logic                halted_q, halted_d;
   logic                cmd_accept;

   assign o_cmd_ready    = (state_q == StIdle) || (state_q == StHalted);
   assign cmd_accept     = i_cmd_valid && o_cmd_ready;
   assign o_pipe_enable  = (state_q == StRun) || (state_q == StStep);
   assign o_pipe_flush   = (state_q == StFlush);
   assign o_dbg_rd_sel   = (state_q == StDumpRd) || (state_q == StDumpTx);
   assign o_dbg_reg_addr = addr_q;
   assign o_tx_data      = tx_data_q;
   assign o_tx_valid     = tx_valid_q;
   assign o_state        = state_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      halted_d   = halted_q;

      case (state_q)
         StIdle: begin
            if (cmd_accept) begin
               case (i_cmd)
                  CmdRun:   state_d = StRun;
                  CmdStep:  state_d = StStep;
                  CmdDump: begin
                     state_d = StDumpRd;
                     addr_d  = '0;
                  end
                  CmdFlush: state_d = StFlush;
                  default:  state_d = StIdle;
               endcase
            end
         end
         StHalted: begin
            if (cmd_accept) begin
               case (i_cmd)
                  CmdDump: begin
                     state_d = StDumpRd;
                     addr_d  = '0;
                  end
                  CmdFlush: state_d = StFlush;
                  default:  state_d = StHalted;
               endcase
            end
         end
         StRun: begin
            if (i_halt) begin
               state_d  = StHalted;
               halted_d = 1'b1;
            end
         end
         StStep: begin
            if (i_halt) begin
               state_d  = StHalted;
               halted_d = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         StDumpRd: begin
            tx_data_d  = i_dbg_reg_data;
            tx_valid_d = 1'b1;
            state_d    = StDumpTx;
         end
         StDumpTx: begin
            if (tx_valid_q && i_tx_ready) begin
               tx_valid_d = 1'b0;
               if (addr_q == LastAddr) begin
                  addr_d  = '0;
                  state_d = halted_q ? StHalted : StIdle;
               end else begin
                  addr_d  = addr_q + NB_REG'(1);
                  state_d = StDumpRd;
               end
            end
         end
         StFlush: begin
            state_d  = StIdle;
            halted_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         halted_q   <= halted_d;
      end
   end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: a vector table for command/state
// sequencing plus hand-written step, run-to-halt, dump, flush and reset cases.
module tb_pipeline_debug_ctrl;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_cmd_valid;
   logic [7:0]  i_cmd;
   logic        o_cmd_ready;
   logic        i_halt;
   logic        o_pipe_enable;
   logic        o_pipe_flush;
   logic        o_dbg_rd_sel;
   logic [4:0]  o_dbg_reg_addr;
   logic [31:0] i_dbg_reg_data;
   logic [31:0] o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic [2:0]  o_state;

   int n_vec = 0;
   int n_err = 0;
   int en_cnt = 0;

   always #5 i_clock = ~i_clock;

   // Register bank model: reg k holds 0x100 + k.
   assign i_dbg_reg_data = 32'h100 + {27'd0, o_dbg_reg_addr};

   always @(negedge i_clock) if (o_pipe_enable === 1'b1) en_cnt++;

   pipeline_debug_ctrl dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_cmd_valid    (i_cmd_valid),
      .i_cmd          (i_cmd),
      .o_cmd_ready    (o_cmd_ready),
      .i_halt         (i_halt),
      .o_pipe_enable  (o_pipe_enable),
      .o_pipe_flush   (o_pipe_flush),
      .o_dbg_rd_sel   (o_dbg_rd_sel),
      .o_dbg_reg_addr (o_dbg_reg_addr),
      .i_dbg_reg_data (i_dbg_reg_data),
      .o_tx_data      (o_tx_data),
      .o_tx_valid     (o_tx_valid),
      .i_tx_ready     (i_tx_ready),
      .o_state        (o_state)
   );

   typedef struct packed {
      logic       rst;
      logic       cv;
      logic [7:0] cmd;
      logic       halt;
      logic [2:0] st;
      logic       en;
      logic       fl;
      logic       rdy;
   } vec_t;

   localparam int NVec = 27;
   vec_t vecs [NVec];

   function automatic vec_t mk(input logic rst, input logic cv, input logic [7:0] cmd,
                               input logic halt, input logic [2:0] st, input logic en,
                               input logic fl, input logic rdy);
      vec_t v;
      v.rst = rst; v.cv = cv; v.cmd = cmd; v.halt = halt;
      v.st = st; v.en = en; v.fl = fl; v.rdy = rdy;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] c);
      i_cmd_valid = 1'b1;
      i_cmd       = c;
      tick();
      i_cmd_valid = 1'b0;
      i_cmd       = 8'h00;
   endtask

   task automatic pulse_reset();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
   endtask

   task automatic do_dump(input logic [2:0] origin, input bit toggle);
      int          words;
      logic        hold;
      logic [31:0] prev;
      words = 0;
      hold  = 1'b0;
      prev  = 32'd0;
      send_cmd(8'h52);
      check("dump_enter_state", {29'd0, o_state}, 32'd3);
      for (int c = 0; c < 400 && words < 32; c++) begin
         if (hold) begin
            check("dump_hold_valid", {31'd0, o_tx_valid}, 32'd1);
            check("dump_hold_data", o_tx_data, prev);
         end
         check("dump_enable_low", {31'd0, o_pipe_enable}, 32'd0);
         i_tx_ready = toggle ? c[0] : 1'b1;
         if (o_tx_valid && i_tx_ready) begin
            check($sformatf("dump_word%0d", words), o_tx_data, 32'h100 + words);
            words++;
         end
         hold = o_tx_valid && !i_tx_ready;
         prev = o_tx_data;
         tick();
      end
      i_tx_ready = 1'b0;
      check("dump_word_count", words, 32'd32);
      check("dump_end_state", {29'd0, o_state}, {29'd0, origin});
      check("dump_end_addr", {27'd0, o_dbg_reg_addr}, 32'd0);
      check("dump_end_valid", {31'd0, o_tx_valid}, 32'd0);
      check("dump_end_rd_sel", {31'd0, o_dbg_rd_sel}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int k;
      i_reset     = 1'b1;
      i_cmd_valid = 1'b0;
      i_cmd       = 8'h00;
      i_halt      = 1'b0;
      i_tx_ready  = 1'b0;
      tick();
      tick();

      //              rst  cv   cmd    halt  st    en   fl   rdy
      vecs[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      vecs[1]  = mk(1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      vecs[2]  = mk(1'b0, 1'b1, 8'h53, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
      vecs[3]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      vecs[4]  = mk(1'b0, 1'b1, 8'h53, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
      vecs[5]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      vecs[6]  = mk(1'b0, 1'b1, 8'h53, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
      vecs[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      vecs[8]  = mk(1'b0, 1'b1, 8'h58, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0);
      vecs[9]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      vecs[10] = mk(1'b0, 1'b1, 8'h53, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
      vecs[12] = mk(1'b0, 1'b1, 8'h53, 1'b0, 3'd6, 1'b0, 1'b0, 1'b1);
      vecs[13] = mk(1'b0, 1'b1, 8'h43, 1'b0, 3'd6, 1'b0, 1'b0, 1'b1);
      vecs[14] = mk(1'b0, 1'b1, 8'h58, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0);
      vecs[15] = mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      vecs[16] = mk(1'b0, 1'b1, 8'h43, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
      vecs[17] = mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
      vecs[18] = mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
      vecs[19] = mk(1'b0, 1'b1, 8'h58, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0);
      vecs[20] = mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      vecs[21] = mk(1'b0, 1'b1, 8'h43, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
      vecs[22] = mk(1'b0, 1'b1, 8'h58, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
      vecs[23] = mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
      vecs[24] = mk(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      vecs[25] = mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
      vecs[26] = mk(1'b1, 1'b1, 8'h43, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < NVec; i++) begin
         i_reset     = vecs[i].rst;
         i_cmd_valid = vecs[i].cv;
         i_cmd       = vecs[i].cmd;
         i_halt      = vecs[i].halt;
         tick();
         check($sformatf("vec%0d_state", i), {29'd0, o_state}, {29'd0, vecs[i].st});
         check($sformatf("vec%0d_enable", i), {31'd0, o_pipe_enable}, {31'd0, vecs[i].en});
         check($sformatf("vec%0d_flush", i), {31'd0, o_pipe_flush}, {31'd0, vecs[i].fl});
         check($sformatf("vec%0d_ready", i), {31'd0, o_cmd_ready}, {31'd0, vecs[i].rdy});
      end
      i_reset     = 1'b0;
      i_cmd_valid = 1'b0;
      i_halt      = 1'b0;
      check("reset_tx_valid", {31'd0, o_tx_valid}, 32'd0);
      check("reset_tx_data", o_tx_data, 32'd0);
      check("reset_addr", {27'd0, o_dbg_reg_addr}, 32'd0);

      // Three single steps give exactly three enabled cycles.
      base = en_cnt;
      repeat (3) begin
         send_cmd(8'h53);
         check("step_state", {29'd0, o_state}, 32'd2);
         tick();
         check("step_back_idle", {29'd0, o_state}, 32'd0);
      end
      tick();
      check("step_pulse_count", en_cnt - base, 32'd3);

      // Run, halt in the tenth RUN cycle.
      send_cmd(8'h43);
      for (int c = 1; c <= 10; c++) begin
         check($sformatf("run_cycle%0d_enable", c), {31'd0, o_pipe_enable}, 32'd1);
         i_halt = (c == 10);
         tick();
      end
      i_halt = 1'b0;
      check("halt_enable_low", {31'd0, o_pipe_enable}, 32'd0);
      check("halt_state", {29'd0, o_state}, 32'd6);
      send_cmd(8'h53);
      check("halted_step_ignored", {29'd0, o_state}, 32'd6);
      check("halted_step_no_enable", {31'd0, o_pipe_enable}, 32'd0);

      do_dump(3'd6, 1'b0);

      // Flush out of HALTED, then run is accepted again.
      send_cmd(8'h58);
      check("flush_high", {31'd0, o_pipe_flush}, 32'd1);
      check("flush_state", {29'd0, o_state}, 32'd5);
      tick();
      check("flush_one_cycle", {31'd0, o_pipe_flush}, 32'd0);
      check("flush_to_idle", {29'd0, o_state}, 32'd0);
      send_cmd(8'h43);
      check("run_after_flush", {29'd0, o_state}, 32'd1);
      pulse_reset();

      do_dump(3'd0, 1'b1);

      // Unknown command is consumed without effect.
      check("unknown_ready", {31'd0, o_cmd_ready}, 32'd1);
      base = en_cnt;
      send_cmd(8'hFF);
      check("unknown_state", {29'd0, o_state}, 32'd0);
      tick();
      tick();
      check("unknown_no_enable", en_cnt - base, 32'd0);

      // Reset while a dump is stalled on word 7.
      send_cmd(8'h52);
      i_tx_ready = 1'b1;
      k = 0;
      while (k < 200 && !(o_state == 3'd4 && o_dbg_reg_addr == 5'd7)) begin
         tick();
         k++;
      end
      i_tx_ready = 1'b0;
      check("middump_reached", {31'd0, k < 200}, 32'd1);
      check("middump_valid", {31'd0, o_tx_valid}, 32'd1);
      i_reset = 1'b1;
      tick();
      tick();
      i_reset = 1'b0;
      check("middump_rst_state", {29'd0, o_state}, 32'd0);
      check("middump_rst_valid", {31'd0, o_tx_valid}, 32'd0);
      check("middump_rst_rd_sel", {31'd0, o_dbg_rd_sel}, 32'd0);
      check("middump_rst_enable", {31'd0, o_pipe_enable}, 32'd0);
      check("middump_rst_addr", {27'd0, o_dbg_reg_addr}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_debug_ctrl.md
Name: pipeline_debug_ctrl

Overview:
- Sequences the five-stage MIPS pipeline from debug commands: continuous run, single step, pipeline flush, and register-bank dump.
- Drives the global stage enable and the stage reset/flush.
- Arbitrates register-bank read port A between the ID stage and the debug dump engine.
- Sits between the debug command source (UART RX) and the pipeline, and feeds dumped words to the UART TX path.

Parameters:
- NB_DATA, 32, register width in bits
- NB_REG, 5, register address width
- N_REGS, 32, number of registers dumped (addresses 0..N_REGS-1)
- NB_CMD, 8, command byte width

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_cmd_valid  in  1  command byte valid
- i_cmd  in  NB_CMD  command byte
- o_cmd_ready  out  1  command accepted this cycle when valid&ready
- i_halt  in  1  HALT instruction reached WB
- o_pipe_enable  out  1  enable for all stage registers and the PC
- o_pipe_flush  out  1  flush/reset to IF/ID/EX/MEM/WB stages
- o_dbg_rd_sel  out  1  1 = read port A addressed by o_dbg_reg_addr instead of inst[25:21]
- o_dbg_reg_addr  out  NB_REG  debug read address
- i_dbg_reg_data  in  NB_DATA  register-bank port A data (combinational read)
- o_tx_data  out  NB_DATA  dumped word
- o_tx_valid  out  1  dumped word valid
- i_tx_ready  in  1  TX consumer ready
- o_state  out  3  current FSM state code (debug visibility)

Behaviour:
- All state is updated on the rising edge of i_clock. Reset is synchronous: i_reset high at an edge forces the conditions below, overriding everything else, including a dump in progress.
- Reset values: state=IDLE, o_pipe_enable=0, o_pipe_flush=0, o_dbg_rd_sel=0, o_dbg_reg_addr=0, o_tx_data=0, o_tx_valid=0, halted flag=0.
- State codes: IDLE=0, RUN=1, STEP=2, DUMP_RD=3, DUMP_TX=4, FLUSH=5, HALTED=6.
- Commands: 0x43 'C' = run, 0x53 'S' = step, 0x52 'R' = dump, 0x58 'X' = flush. Any other byte is consumed and ignored; state is unchanged.
- o_cmd_ready=1 only in IDLE and HALTED, otherwise 0.
- In HALTED only 'R' and 'X' act; 'C' and 'S' are consumed and ignored.
- o_pipe_enable is combinational: 1 iff state is RUN or STEP.
- o_pipe_flush is combinational: 1 iff state is FLUSH.
- o_dbg_rd_sel=1 iff state is DUMP_RD or DUMP_TX.
- IDLE -'C'-> RUN; IDLE -'S'-> STEP; IDLE/HALTED -'R'-> DUMP_RD with addr=0, saving the return state; IDLE/HALTED -'X'-> FLUSH.
- RUN: enable stays high each cycle. When i_halt=1, go to HALTED; the halt cycle itself is enabled, and enable is 0 from the next cycle.
- STEP: exactly one enabled cycle, then IDLE, or HALTED if i_halt=1 in that cycle.
- DUMP_RD: one cycle with the address driven. At the edge, o_tx_data <= i_dbg_reg_data and o_tx_valid <= 1, then go to DUMP_TX.
- DUMP_TX: hold o_tx_data and o_tx_valid stable while i_tx_ready=0. On valid&ready:
  - if addr==N_REGS-1: o_tx_valid <= 0, addr <= 0, return to the saved state (IDLE or HALTED);
  - else: addr <= addr+1, o_tx_valid <= 0, go to DUMP_RD.
- Word rate: at most one word per 2 cycles.
- FLUSH: one cycle, then IDLE. The halted flag is cleared.
- o_pipe_enable=0 throughout dump and flush, so the pipeline is frozen.
- i_halt is ignored outside RUN and STEP.
- A command arriving while ready=0 is not consumed; the source must hold it.

Test Plan:
- Reset: hold i_reset 2 cycles mid-dump (state DUMP_TX, addr=7) -> next cycle state=0, o_tx_valid=0, o_dbg_rd_sel=0, o_pipe_enable=0.
- Step: send 'S' (0x53) from IDLE -> o_pipe_enable high exactly 1 cycle, then state=0. Repeat 3 times -> 3 enable pulses total.
- Run to halt: send 'C', assert i_halt at cycle 10 of RUN -> enable high through cycle 10, low from cycle 11, state=6. A subsequent 'S' is ignored and state stays 6.
- Dump with backpressure: preload reg k = 0x100+k, send 'R', i_tx_ready toggling 1/0 -> 32 words 0x100..0x11F in order, each stable while not ready. Ends in the origin state; o_dbg_reg_addr=0.
- Flush: from HALTED send 'X' -> o_pipe_flush high 1 cycle, then state=0, and 'C' is accepted again.
- Unknown command 0xFF in IDLE -> o_cmd_ready=1, consumed, state stays 0, no enable pulse.
